// File: rtl/shared_memory_arbiter.sv
// Shared word-addressed RAM arbitrated between NUM_PORTS requesters with a
// req/ack handshake, WAIT_STATES extra cycles per access and per-port stall.
// Optional feature: define ROUND_ROBIN_EN for round-robin arbitration;
// without it the lowest requesting port index wins.
//
// state  | meaning
// IDLE   | no access in flight; arbitrate among pending requests
// ACCESS | wait counter running down; commit write / capture read at zero
// DONE   | ack pulse to the winner, rdata/err valid, then back to IDLE
module shared_memory_arbiter #(
   parameter int NUM_PORTS   = 2,
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 32,
   parameter int MEM_DEPTH   = 256,
   parameter int WAIT_STATES = 0
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [NUM_PORTS-1:0]              req,
   input  logic [NUM_PORTS-1:0]              we,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   addr,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]   wdata,
   input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] be,
   output logic [NUM_PORTS-1:0]              ack,
   output logic [DATA_WIDTH-1:0]             rdata,
   output logic                              err,
   output logic [NUM_PORTS-1:0]              stall,
   output logic                              busy
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int OFF_W = $clog2(BYTES);
   localparam int IDX_W = ADDR_WIDTH - OFF_W;
   localparam int PW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int MAW   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(MEM_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

   state_t                  state_q, state_d;
   logic [3:0]              wait_cnt_q;
   logic [PW-1:0]           win_q, win_d;
   logic                    lat_we_q;
   logic [ADDR_WIDTH-1:0]   lat_addr_q;
   logic [DATA_WIDTH-1:0]   lat_wdata_q;
   logic [BYTES-1:0]        lat_be_q;
   logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];
   logic [IDX_W-1:0]        word_idx;
   logic                    in_range;
   logic                    commit;

   assign word_idx = lat_addr_q[ADDR_WIDTH-1:OFF_W];
   assign in_range = (word_idx < DEPTH_IDX);
   assign commit   = (state_q == S_ACCESS) && (wait_cnt_q == 4'd0);

`ifdef ROUND_ROBIN_EN
   logic [PW-1:0] rr_ptr_q;

   // Winner is the first requester at or after the pointer, wrapping.
   always_comb begin
      win_d = '0;
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         if (req[(int'(rr_ptr_q) + i) % NUM_PORTS])
            win_d = PW'((int'(rr_ptr_q) + i) % NUM_PORTS);
      end
   end

   // Pointer moves past the port that was just acknowledged.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         rr_ptr_q <= '0;
      else if (state_q == S_DONE)
         rr_ptr_q <= (win_q == PW'(NUM_PORTS - 1)) ? '0 : win_q + 1'b1;
   end
`else
   // Fixed priority: lowest requesting index wins.
   always_comb begin
      win_d = '0;
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         if (req[i])
            win_d = PW'(i);
      end
   end
`endif

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (|req) state_d = S_ACCESS;
         S_ACCESS: if (wait_cnt_q == 4'd0) state_d = S_DONE;
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Request capture, wait-state down-counter and read/err result registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt_q  <= '0;
         win_q       <= '0;
         lat_we_q    <= 1'b0;
         lat_addr_q  <= '0;
         lat_wdata_q <= '0;
         lat_be_q    <= '0;
         rdata       <= '0;
         err         <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (|req) begin
                  win_q       <= win_d;
                  lat_we_q    <= we[win_d];
                  lat_addr_q  <= addr[int'(win_d)*ADDR_WIDTH +: ADDR_WIDTH];
                  lat_wdata_q <= wdata[int'(win_d)*DATA_WIDTH +: DATA_WIDTH];
                  lat_be_q    <= be[int'(win_d)*BYTES +: BYTES];
                  wait_cnt_q  <= 4'(WAIT_STATES);
               end
            end
            S_ACCESS: begin
               if (wait_cnt_q != 4'd0) begin
                  wait_cnt_q <= wait_cnt_q - 4'd1;
               end else begin
                  err <= ~in_range;
                  if (!lat_we_q && in_range)
                     rdata <= mem[word_idx[MAW-1:0]];
               end
            end
            S_DONE: begin
               rdata <= '0;
               err   <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // Byte-enabled RAM write at the commit edge; out-of-range writes dropped.
   always_ff @(posedge clk) begin
      if (commit && lat_we_q && in_range) begin
         for (int b = 0; b < BYTES; b++) begin
            if (lat_be_q[b])
               mem[word_idx[MAW-1:0]][b*8 +: 8] <= lat_wdata_q[b*8 +: 8];
         end
      end
   end

   // One-hot ack in DONE plus stall/busy status.
   always_comb begin
      for (int i = 0; i < NUM_PORTS; i++)
         ack[i] = (state_q == S_DONE) && (win_q == PW'(i));
      stall = req & ~ack;
      busy  = (state_q != S_IDLE);
   end

endmodule

// File: tb/tb_shared_memory_arbiter.sv
module tb_shared_memory_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic [1:0]  req, we, ack, stall;
   logic [63:0] addr, wdata;
   logic [7:0]  be;
   logic [31:0] rdata;
   logic        err, busy;

   logic        req1, we1, ack1, stall1, err1, busy1;
   logic [31:0] addr1, wdata1, rdata1;
   logic [3:0]  be1;

   shared_memory_arbiter dut0 (
      .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .be(be), .ack(ack), .rdata(rdata), .err(err), .stall(stall), .busy(busy)
   );

   shared_memory_arbiter #(.NUM_PORTS(1), .WAIT_STATES(3)) dut1 (
      .clk(clk), .reset(reset), .req(req1), .we(we1), .addr(addr1), .wdata(wdata1),
      .be(be1), .ack(ack1), .rdata(rdata1), .err(err1), .stall(stall1), .busy(busy1)
   );

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      int          port;
      logic [31:0] rdata;
      logic        err;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } vec_t;
   vec_t tbl[13];

   logic [31:0] model [int];

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic timeout(string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got no ack expected ack within budget", name);
   endtask

   // Reference model: computes expected response and updates model RAM.
   function automatic void predict(int p, logic w, logic [31:0] a, logic [31:0] d, logic [3:0] b);
      exp_t        e;
      int          idx;
      logic [31:0] cur;
      idx     = int'(a >> 2);
      e.port  = p;
      e.err   = (idx >= 256);
      e.rdata = 32'h0;
      cur     = model.exists(idx) ? model[idx] : 32'hxxxxxxxx;
      if (!e.err) begin
         if (w) begin
            for (int k = 0; k < 4; k++)
               if (b[k]) cur[k*8 +: 8] = d[k*8 +: 8];
            model[idx] = cur;
         end else begin
            e.rdata = cur;
         end
      end
      sb.push_back(e);
   endfunction

   task automatic drive(int p, logic w, logic [31:0] a, logic [31:0] d, logic [3:0] b);
      req[p]          = 1'b1;
      we[p]           = w;
      addr[p*32 +: 32]  = a;
      wdata[p*32 +: 32] = d;
      be[p*4 +: 4]      = b;
   endtask

   // Advance at least one cycle, then until any ack; stall must track req while waiting.
   task automatic wait_ack(output int lat);
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
         if (ack == 2'b00)
            check("stall_wait", 32'(stall), 32'(req));
      end while (lat < 20 && ack == 2'b00);
   endtask

   task automatic score();
      exp_t e;
      if (sb.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL unexpected_ack: got ack %b expected none", ack);
      end else begin
         e = sb.pop_front();
         check("ack_port", 32'(ack), 32'(2'b01 << e.port));
         check("rdata", rdata, e.rdata);
         check("err", 32'(err), 32'(e.err));
         check("stall_acked", 32'(stall[e.port]), 32'd0);
      end
   endtask

   task automatic access(int p, logic w, logic [31:0] a, logic [31:0] d, logic [3:0] b);
      int lat;
      predict(p, w, a, d, b);
      drive(p, w, a, d, b);
      wait_ack(lat);
      if (ack == 2'b00) begin
         timeout("access_ack");
         void'(sb.pop_front());
      end else begin
         check("latency", lat, 32'd2);
         score();
      end
      req[p] = 1'b0;
      @(posedge clk); #1;
      check("rdata_cleared", rdata, 32'h0);
      check("ack_low", 32'(ack), 32'h0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req   = '0;
      req1  = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   // Access on the single-port, three-wait-state instance.
   task automatic access1(logic w, logic [31:0] a, logic [31:0] d, logic [3:0] b, logic [31:0] exp_rd);
      int lat;
      int nb;
      lat = 0;
      nb  = 0;
      req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; be1 = b;
      do begin
         @(posedge clk); #1;
         lat++;
         if (busy1) nb++;
      end while (lat < 30 && !ack1);
      if (!ack1) begin
         timeout("ws_ack");
      end else begin
         check("ws_latency", lat, 32'd5);
         check("ws_rdata", rdata1, exp_rd);
         check("ws_err", 32'(err1), 32'd0);
      end
      req1 = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         if (busy1) nb++;
      end
      check("ws_busy_cycles", nb, 32'd5);
   endtask

   initial begin
      int lat;
      logic [1:0] exp_port;

      tbl[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF};
      tbl[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0};
      tbl[2]  = '{1'b1, 32'h0000_0020, 32'hAAAA_AAAA, 4'hF};
      tbl[3]  = '{1'b1, 32'h0000_0020, 32'h1122_3344, 4'h5};
      tbl[4]  = '{1'b0, 32'h0000_0020, 32'h0,         4'hF};
      tbl[5]  = '{1'b1, 32'h0000_0023, 32'h5566_7788, 4'h0};
      tbl[6]  = '{1'b0, 32'h0000_0021, 32'h0,         4'h0};
      tbl[7]  = '{1'b1, 32'h0000_03FC, 32'h1234_5678, 4'hF};
      tbl[8]  = '{1'b0, 32'h0000_03FE, 32'h0,         4'h0};
      tbl[9]  = '{1'b0, 32'h0000_0400, 32'h0,         4'hF};
      tbl[10] = '{1'b1, 32'h0000_0400, 32'hCAFE_F00D, 4'hF};
      tbl[11] = '{1'b1, 32'h0000_0410, 32'hFFFF_FFFF, 4'hF};
      tbl[12] = '{1'b0, 32'h0000_0010, 32'h0,         4'h0};

      reset = 1'b1;
      req = '0; we = '0; addr = '0; wdata = '0; be = '0;
      req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0; be1 = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ack", 32'(ack), 32'h0);
      check("rst_rdata", rdata, 32'h0);
      check("rst_err", 32'(err), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_busy1", 32'(busy1), 32'h0);
      reset = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 13; i++)
         access(0, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be);

      // Simultaneous requests: port0 write then port1 reads the new value.
      do_reset();
      predict(0, 1'b1, 32'h30, 32'h0BAD_F00D, 4'hF);
      predict(1, 1'b0, 32'h30, 32'h0, 4'h0);
      drive(0, 1'b1, 32'h30, 32'h0BAD_F00D, 4'hF);
      drive(1, 1'b0, 32'h30, 32'h0, 4'h0);
      wait_ack(lat);
      if (ack == 2'b00) timeout("dual_ack0");
      else begin
         check("dual_lat0", lat, 32'd2);
         check("dual_stall1", 32'(stall[1]), 32'd1);
         score();
      end
      req[0] = 1'b0;
      wait_ack(lat);
      if (ack == 2'b00) timeout("dual_ack1");
      else begin
         check("dual_lat1", lat, 32'd3);
         score();
      end
      req[1] = 1'b0;
      @(posedge clk); #1;

      // Both ports requesting continuously for four grants.
      do_reset();
      drive(0, 1'b0, 32'h10, 32'h0, 4'h0);
      drive(1, 1'b0, 32'h20, 32'h0, 4'h0);
      for (int g = 0; g < 4; g++) begin
`ifdef ROUND_ROBIN_EN
         exp_port = 2'(g % 2);
`else
         exp_port = 2'd0;
`endif
         predict(int'(exp_port), 1'b0, exp_port == 2'd0 ? 32'h10 : 32'h20, 32'h0, 4'h0);
         wait_ack(lat);
         if (ack == 2'b00) begin
            timeout("grant_ack");
            void'(sb.pop_front());
         end else begin
            check("grant_lat", lat, g == 0 ? 32'd2 : 32'd3);
            score();
         end
      end
      req = '0;
      @(posedge clk); #1;

      // Reset during ACCESS aborts the write.
      drive(0, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'hF);
      @(posedge clk); #1;
      check("abort_busy_pre", 32'(busy), 32'd1);
      reset = 1'b1;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_ack", 32'(ack), 32'd0);
      req = '0;
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         check("abort_no_ack", 32'(ack), 32'd0);
      end
      access(0, 1'b0, 32'h10, 32'h0, 4'h0);

      // Three wait states on the single-port instance.
      access1(1'b1, 32'h40, 32'h5A5A_1234, 4'hF, 32'h0);
      access1(1'b0, 32'h40, 32'h0, 4'h0, 32'h5A5A_1234);

      if (sb.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
